// File: rtl/reg_out_fifo_if.sv
// Handshake bundle between the register-output FIFO and its neighbours.
// Combinational wires only, so it adds no latency.
// Backpressure is carried by in_ready (to upstream) and out_ready (from downstream).
interface reg_out_fifo_if #(
    parameter int N     = 10,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;

    // FIFO side: accepts words from upstream and presents the head downstream
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, overflow
    );

    // Environment side: produces words and consumes the head
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, overflow
    );
endinterface

// File: rtl/reg_out_fifo.sv
// Synchronous first-word-fall-through FIFO capturing register output words.
// Latency: a word written at edge k is visible at the head in cycle k+1.
// Backpressure: in_ready drops when full; offered words are dropped and flagged.
module reg_out_fifo #(
    parameter int N     = 10,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    reg_out_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    // Occupancy is held in a separate counter so full and empty never alias
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A full FIFO refuses writes even when a read frees a slot the same cycle
    assign wr_en = bus.in_valid  && !full;
    assign rd_en = bus.out_ready && !empty;

    // Next-state for pointers, occupancy and the sticky overflow flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
        if (bus.in_valid && full) begin
            overflow_d = 1'b1;
        end
    end

    // Control state; reset discards contents and overrides any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is never cleared; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // Status and head are derived from registered state only
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
endmodule
